// File: rtl/bus_arbiter_4x1.sv
// bus_arbiter_4x1
//
// Round-robin arbiter and sequencer for the shared 4:1 datapath mux.
// Four requesters compete for the bus. The winner is granted in BUSY, and
// its data word is registered onto Y with VALID. Every release passes
// through at least one TURN cycle with no grant, so ownership never moves
// directly from one requester to another. While other requesters are
// pending, an owner is limited to MAX_HOLD consecutive grant cycles.
//
// Parameters:
//   DATA_WIDTH  width of the data words (32)
//   MAX_HOLD    maximum consecutive grant cycles under contention (1..255)
//
// Ports:
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-low reset
//   REQ    in   [3:0] level requests, bit i = requester i
//   D0..D3 in   [DATA_WIDTH-1:0] requester data words
//   GNT    out  [3:0] registered one-hot grant, zero when there is no owner
//   SEL    out  [1:0] registered mux select, the current or last owner
//   Y      out  [DATA_WIDTH-1:0] registered bus word
//   VALID  out  Y holds a word captured from the current owner

module bus_arbiter_4x1 #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            REQ,
  input  logic [DATA_WIDTH-1:0] D0,
  input  logic [DATA_WIDTH-1:0] D1,
  input  logic [DATA_WIDTH-1:0] D2,
  input  logic [DATA_WIDTH-1:0] D3,
  output logic [3:0]            GNT,
  output logic [1:0]            SEL,
  output logic [DATA_WIDTH-1:0] Y,
  output logic                  VALID
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    TURN = 2'b10
  } state_t;

  state_t                state;
  logic [1:0]            last;
  logic [7:0]            hold;

  logic [1:0]            winner;
  logic [1:0]            cand;
  logic                  found;
  logic [3:0]            owner_mask;
  logic                  others_pending;
  logic                  release_now;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] d_sel;

  // The search starts one past the last owner and wraps around. The last
  // owner is tried last, which gives the round-robin rotation.
  always_comb begin
    winner = last;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + k[1:0];
      if (!found && REQ[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // An owner gives up the bus when it drops its request. It is also forced
  // off once its quota is used up, but only if somebody else is waiting.
  always_comb begin
    owner_mask     = 4'b0001 << SEL;
    others_pending = |(REQ & ~owner_mask);
    hold_full      = (hold == 8'(MAX_HOLD));
    release_now    = !REQ[SEL] || (hold_full && others_pending);
  end

  always_comb begin
    case (SEL)
      2'd0:    d_sel = D0;
      2'd1:    d_sel = D1;
      2'd2:    d_sel = D2;
      default: d_sel = D3;
    endcase
  end

  // Single state machine. Data capture looks at the state before the edge.
  // The word is therefore taken one edge after the grant appears, and once
  // more on the edge that releases the grant. SEL is left alone when the
  // grant drops, so the mux select stays on the last owner.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      GNT   <= '0;
      SEL   <= '0;
      Y     <= '0;
      VALID <= 1'b0;
      last  <= 2'b11;
      hold  <= '0;
    end else begin
      if (state == BUSY) begin
        Y     <= d_sel;
        VALID <= 1'b1;
      end else begin
        VALID <= 1'b0;
      end

      case (state)
        IDLE, TURN: begin
          if (found) begin
            state <= BUSY;
            GNT   <= 4'b0001 << winner;
            SEL   <= winner;
            last  <= winner;
            hold  <= 8'd1;
          end else begin
            state <= IDLE;
            GNT   <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state <= TURN;
            GNT   <= '0;
          end else if (!hold_full) begin
            hold <= hold + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4x1.sv
// tb_bus_arbiter_4x1
//
// Directed testbench for bus_arbiter_4x1 with MAX_HOLD = 8. Each scenario
// task drives its stimulus and checks the outputs one time unit after the
// rising edge. The expected values are written out in the task.

module tb_bus_arbiter_4x1;

  localparam int DW = 32;
  localparam int MH = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] d0, d1, d2, d3;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] y;
  logic          valid;

  int n_checks;
  int n_fail;

  bus_arbiter_4x1 #(.DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .REQ  (req),
    .D0   (d0),
    .D1   (d1),
    .D2   (d2),
    .D3   (d3),
    .GNT  (gnt),
    .SEL  (sel),
    .Y    (y),
    .VALID(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Reset values, the grant order after reset, and the asynchronous clear
  // in the middle of a grant.
  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    d0    = 32'h1234_5678;
    #2;
    n_checks++;
    if ({gnt, sel, valid} !== 7'b0 || y !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: gnt=%b sel=%b valid=%b y=%h, required all zero", gnt, sel, valid, y);
    end
    step();
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    n_checks++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_first_grant: gnt=%b sel=%0d, required 0001 sel 0", gnt, sel);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 32'h1234_5678) begin
      n_fail++;
      $display("[TB] FAIL reset_first_data: valid=%b y=%h, required 1 12345678", valid, y);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, sel, valid} !== 7'b0 || y !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_async: gnt=%b sel=%b valid=%b y=%h, required all zero", gnt, sel, valid, y);
    end
    req = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    do_reset();
    d2  = 32'h9999_ffdd;
    req = 4'b0100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_grant: gnt=%b sel=%0d valid=%b, required 0100 sel 2 valid 0", gnt, sel, valid);
    end
    step();
    n_checks++;
    if (y !== 32'h9999_ffdd || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_data: y=%h valid=%b, required 9999ffdd valid 1", y, valid);
    end
    req = 4'b0000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd2 || valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_release: gnt=%b sel=%0d valid=%b, required 0000 sel 2 valid 1", gnt, sel, valid);
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || y !== 32'h9999_ffdd) begin
      n_fail++;
      $display("[TB] FAIL single_hold_y: valid=%b y=%h, required 0 9999ffdd", valid, y);
    end
  endtask

  // All four requesters are held. Each one gets exactly MAX_HOLD grant
  // cycles, followed by a single cycle with no grant.
  task automatic test_contention;
    logic [DW-1:0] dv [4];
    logic [3:0]    eg;
    dv[0] = 32'hA0A0_0000;
    dv[1] = 32'hB1B1_1111;
    dv[2] = 32'hC2C2_2222;
    dv[3] = 32'hD3D3_3333;
    do_reset();
    d0 = dv[0]; d1 = dv[1]; d2 = dv[2]; d3 = dv[3];
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << (g % 4);
      for (int c = 0; c < MH; c++) begin
        step();
        n_checks++;
        if (gnt !== eg || sel !== 2'(g % 4) || valid !== (c != 0)) begin
          n_fail++;
          $display("[TB] FAIL contention_grant g%0d c%0d: gnt=%b sel=%0d valid=%b, required %b sel %0d valid %0d",
                   g, c, gnt, sel, valid, eg, g % 4, (c != 0));
        end
        if (c != 0) begin
          n_checks++;
          if (y !== dv[g % 4]) begin
            n_fail++;
            $display("[TB] FAIL contention_data g%0d c%0d: y=%h, required %h", g, c, y, dv[g % 4]);
          end
        end
      end
      if (g < 4) begin
        step();
        n_checks++;
        if (gnt !== 4'b0000 || sel !== 2'(g % 4)) begin
          n_fail++;
          $display("[TB] FAIL contention_turn g%0d: gnt=%b sel=%0d, required 0000 sel %0d", g, gnt, sel, g % 4);
        end
      end
    end
    req = 4'b0000;
  endtask

  // Owner 1 drops its request after 3 cycles while requester 3 waits.
  task automatic test_voluntary;
    do_reset();
    d1  = 32'h1111_0001;
    d3  = 32'h3333_0003;
    req = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (gnt !== 4'b0010) begin
        n_fail++;
        $display("[TB] FAIL voluntary_owner c%0d: gnt=%b, required 0010", c, gnt);
      end
    end
    req = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || valid !== 1'b1 || y !== 32'h1111_0001) begin
      n_fail++;
      $display("[TB] FAIL voluntary_turn: gnt=%b valid=%b y=%h, required 0000 1 11110001", gnt, valid, y);
    end
    step();
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL voluntary_next: gnt=%b sel=%0d valid=%b, required 1000 sel 3 valid 0", gnt, sel, valid);
    end
    step();
    n_checks++;
    if (valid !== 1'b1 || y !== 32'h3333_0003) begin
      n_fail++;
      $display("[TB] FAIL voluntary_data: valid=%b y=%h, required 1 33330003", valid, y);
    end
    req = 4'b0000;
  endtask

  // A lone requester keeps the grant well past MAX_HOLD, and Y follows D1
  // one cycle behind.
  task automatic test_lone;
    logic [DW-1:0] v;
    do_reset();
    d1  = 32'h0;
    req = 4'b0010;
    step();
    for (int i = 0; i < 20; i++) begin
      case (i)
        0:       v = 32'h0000_0001;
        1:       v = 32'hFFFF_FFFF;
        default: v = 32'h0101_0101 * i;
      endcase
      d1 = v;
      step();
      n_checks++;
      if (gnt !== 4'b0010 || valid !== 1'b1 || y !== v) begin
        n_fail++;
        $display("[TB] FAIL lone_owner i%0d: gnt=%b valid=%b y=%h, required 0010 1 %h", i, gnt, valid, y, v);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_rotation;
    do_reset();
    req = 4'b1100;
    step();
    n_checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL rotation_first: gnt=%b sel=%0d, required 0100 sel 2", gnt, sel);
    end
    step();
    req = 4'b1000;
    step();
    n_checks++;
    if (gnt !== 4'b0000 || sel !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL rotation_turn: gnt=%b sel=%0d, required 0000 sel 2", gnt, sel);
    end
    step();
    n_checks++;
    if (gnt !== 4'b1000 || sel !== 2'd3) begin
      n_fail++;
      $display("[TB] FAIL rotation_second: gnt=%b sel=%0d, required 1000 sel 3", gnt, sel);
    end
    req = 4'b0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    test_reset();
    test_single();
    test_contention();
    test_voluntary();
    test_lone();
    test_rotation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_4x1.md
# bus_arbiter_4x1

Round-robin arbiter and sequencer for the shared 32-bit 4:1 datapath mux (`MUX32_4x1`). It arbitrates among four requesters and drives the mux select. It captures the selected word into a registered output with a valid flag. It also enforces a per-grant hold quota and a one-cycle bus turnaround between owners. It sits between the requesting units (PC/ALU/register-file/memory ports) and the shared data bus.

## Interface
- `DATA_WIDTH`, 32: data width; equals `` `DATA_INDEX_LIMIT``+1 from `prj_definition.v`.
- `MAX_HOLD`, 8: maximum consecutive granted cycles while another requester is pending; legal range 1..255.
- `CLK`  input  1  system clock; all state updates on the rising edge.
- `RST`  input  1  reset; asynchronous and active-low, clears all state immediately.
- `REQ`  input  4  level request, bit i = requester i.
- `D0`..`D3`  input  DATA_WIDTH each  requester data words.
- `GNT`  output  4  one-hot grant, registered; all zeros when no owner.
- `SEL`  output  2  mux select = index of current or last owner, registered.
- `Y`  output  DATA_WIDTH  registered bus word.
- `VALID`  output  1  `Y` holds a word captured from the current owner.

## Operation
- The block has three states: IDLE, BUSY and TURN.
- Internal registers:
  - `LAST[1:0]`: last granted index.
  - `HOLD[7:0]`: cycles granted to the current owner.
- Priority order at arbitration is `LAST+1`, `LAST+2`, `LAST+3`, `LAST` (mod 4). The first asserted `REQ` bit wins.
- IDLE or TURN, any `REQ` set:
  - go to BUSY
  - set `GNT` one-hot to the winner, `SEL` = winner, `LAST` = winner, `HOLD` = 1.
- IDLE or TURN, `REQ`=0000: go to (or stay in) IDLE with `GNT`=0000.
- BUSY, release conditions:
  - If `REQ[owner]`=0, release.
  - Also release when `HOLD`==`MAX_HOLD` and any other `REQ` bit is set (forced release).
  - On release: `GNT`=0000, go to TURN.
- BUSY, no release: keep the grant. `HOLD` increments and saturates at `MAX_HOLD`.
  - A lone owner keeps the grant indefinitely.
- A grant is never transferred directly between owners. At least one TURN cycle with `GNT`=0000 always separates two grants.
- Data capture:
  - Each edge where the state is BUSY: `Y` <= D[`SEL`] and `VALID` <= 1.
  - Otherwise `VALID` <= 0 and `Y` holds its value.
- `SEL` keeps the last owner index while `GNT`=0000, so the mux select never glitches.
- Requests that rise and fall entirely within a cycle not sampled by an edge are ignored. There is no request latching.

## Timing
- Reset (`RST`=0, asynchronous): state IDLE, `GNT`=0000, `SEL`=00, `Y`=0, `VALID`=0, `LAST`=11, `HOLD`=0.
  - `LAST`=11 gives requester 0 first priority after reset.
  - Reset asserted mid-grant clears all outputs without waiting for a clock edge.
  - Deassertion is synchronous to the next rising edge.
- Request to grant: 1 edge. `REQ` is sampled high at edge N, and `GNT` and `SEL` are valid after edge N.
- Grant to data: 1 edge. `VALID`=1 and `Y`=D[owner] after edge N+1. `Y` tracks `D` with one cycle of latency while BUSY.
- Release: `REQ[owner]` sampled low at edge M gives `GNT`=0000 after M. `VALID` falls after M+1, and `Y` keeps the last word captured in BUSY.
- Turnaround: the next grant appears after edge M+1 at the earliest.
- Forced release: with a competitor pending, an owner receives exactly `MAX_HOLD` grant cycles. Grant period plus turnaround = `MAX_HOLD`+1 cycles.
- Simultaneous release and new requests at the same edge: the release wins. Arbitration happens in TURN on the following edge using the updated `LAST`.

## Test plan
- Reset: `RST`=0 mid-operation with no clock edge -> `GNT`=0000, `SEL`=00, `Y`=0, `VALID`=0 immediately. After release, `REQ`=1111 grants requester 0 first.
- Single request: `REQ`=0100, `D2`=h9999ffdd -> `GNT`=0100 and `SEL`=10 after 1 edge. `Y`=h9999ffdd and `VALID`=1 after 2 edges.
- Full contention: `REQ`=1111 held, `MAX_HOLD`=8 -> grants 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles and is followed by one `GNT`=0000 cycle.
- Voluntary release: owner 1 drops `REQ` after 3 granted cycles while `REQ[3]`=1 -> `GNT`=0000 for 1 cycle, then `GNT`=1000, `SEL`=11. `VALID` shows a one-cycle gap.
- Lone owner: `REQ`=0010 for 20 cycles, `MAX_HOLD`=8 -> `GNT`=0010 continuously with no TURN cycle. `Y` follows `D1` with 1-cycle lag (e.g. h00000001, then hffffffff).
- Rotation after reset: `LAST`=11 reset value, `REQ`=1100 -> requester 2 is granted first, then requester 3 after its release.
